data_mem_pipe: RTL and testbench

Parametrised successor to the single-cycle data memory. It is a word-organised synchronous RAM with byte-enable writes and a configurable read latency (1–4 cycles). A ready/valid request–response handshake lets the core's LSU stall on it. It also flags misaligned and out-of-range accesses instead of silently aliasing them. It sits on the core data bus between the LSU and the peripheral address decoder.

---
 rtl/data_mem_pipe.sv | 147 ++++++++++++++
 tb/tb_data_mem_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Word-organised data RAM with byte-enable writes, ready/valid request handshake and error flagging.
// Latency: response strobe READ_LATENCY (1..4) cycles after the accept cycle; one response per request, in order.
// Backpressure: ready_o drops while a multi-cycle response is pending; requests are held by the requester until accepted.
module data_mem_pipe #(
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] read_data_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] IDLE_DATA = 32'hfa11_1eaf;
    localparam logic [31:0] ERR_DATA  = 32'hdead_beef;

    // Elaboration-time guard on the legal parameter space.
    if (DEPTH_WORDS < 16 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_pipe: DEPTH_WORDS must be a power of two and at least 16");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_mem_pipe: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Storage: never reset, so a write committed just before a reset survives it.
    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    // Goes high on the first clock after reset release; keeps ready_o low during reset.
    logic        live_q;

    // Captured response: error flag plus the data word to present in RESP.
    logic        err_q;
    logic [31:0] data_q;

    // Request decode.
    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          misaligned;
    logic          out_of_range;
    logic          req_err;
    logic          accept;
    logic          ram_write;

    assign word_idx     = addr_i[31:2];
    assign ram_idx      = word_idx[AW-1:0];
    assign misaligned   = |addr_i[1:0];
    assign out_of_range = (word_idx >= 30'(DEPTH_WORDS));
    assign req_err      = misaligned | out_of_range;
    assign accept       = mem_req_i & ready_o;
    assign ram_write    = accept & write_enable_i & ~req_err;

    // State register: FSM state, latency counter and out-of-reset flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic: RESP behaves like IDLE for a new acceptance, enabling back-to-back at latency 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (READ_LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(READ_LATENCY - 1);
                    end
                end else if (state_q == ST_RESP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Output decode: purely from registered state, no input-to-output path.
    always_comb begin
        ready_o     = live_q && (state_q != ST_WAIT);
        rvalid_o    = (state_q == ST_RESP);
        err_o       = (state_q == ST_RESP) && err_q;
        read_data_o = (state_q == ST_RESP) ? data_q : IDLE_DATA;
    end

    // Response capture at the acceptance edge; the read word is sampled before any later write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q  <= 1'b0;
            data_q <= IDLE_DATA;
        end else if (accept) begin
            err_q <= req_err;
            if (req_err) begin
                data_q <= ERR_DATA;
            end else if (write_enable_i) begin
                data_q <= IDLE_DATA;
            end else begin
                data_q <= mem[ram_idx];
            end
        end
    end

    // Byte-lane write on the acceptance edge; erroneous requests leave the RAM untouched.
    always_ff @(posedge clk_i) begin
        if (ram_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_enable_i[k]) begin
                    mem[ram_idx][8*k +: 8] <= write_data_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: three instances at read latency 1, 3 and 4.
// Table-driven requests with a per-instance response scoreboard checked on rvalid_o.
// Hand-written sequences cover reset, idle levels and reset during an in-flight request.
module tb_data_mem_pipe;

    localparam logic [31:0] IDLE_DATA = 32'hfa11_1eaf;
    localparam logic [31:0] ERR_DATA  = 32'hdead_beef;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n [3];
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        rdy   [3];
    logic        rv    [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    data_mem_pipe #(.DEPTH_WORDS(4096), .READ_LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .mem_req_i(req[0]), .write_enable_i(we[0]),
        .byte_enable_i(be[0]), .addr_i(addr[0]), .write_data_i(wdata[0]),
        .ready_o(rdy[0]), .rvalid_o(rv[0]), .err_o(err[0]), .read_data_o(rdata[0]));

    data_mem_pipe #(.DEPTH_WORDS(4096), .READ_LATENCY(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .mem_req_i(req[1]), .write_enable_i(we[1]),
        .byte_enable_i(be[1]), .addr_i(addr[1]), .write_data_i(wdata[1]),
        .ready_o(rdy[1]), .rvalid_o(rv[1]), .err_o(err[1]), .read_data_o(rdata[1]));

    data_mem_pipe #(.DEPTH_WORDS(4096), .READ_LATENCY(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .mem_req_i(req[2]), .write_enable_i(we[2]),
        .byte_enable_i(be[2]), .addr_i(addr[2]), .write_data_i(wdata[2]),
        .ready_o(rdy[2]), .rvalid_o(rv[2]), .err_o(err[2]), .read_data_o(rdata[2]));

    typedef struct {
        int          dut;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic int lat_of(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push_exp(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop_exp(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d): got 0x%08h, want 0x%08h at cycle %0d", name, d, act, exp, cyc);
        end
    endfunction

    function automatic void add(int d, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] wd,
                                logic e, logic [31:0] ed, int st);
        vec_t v;
        v.dut = d; v.we = w; v.be = b; v.addr = a; v.wdata = wd;
        v.exp_err = e; v.exp_data = ed; v.exp_stall = st;
        tbl.push_back(v);
    endfunction

    // Response monitor: every rvalid_o must match the oldest expected response, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rv[i] === 1'b1) begin
                if (qsize(i) == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_rvalid (dut%0d): got rvalid_o=1, want no response at cycle %0d", i, cyc);
                end else begin
                    e = pop_exp(i);
                    chk("resp_err",   i, 32'(err[i]), 32'(e.err));
                    chk("resp_data",  i, rdata[i], e.data);
                    chk("resp_cycle", i, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("idle_data", i, rdata[i], IDLE_DATA);
            end
        end
    end

    // Drive one request, hold it until accepted, optionally register its expected response.
    task automatic issue(input vec_t v, input bit track);
        int   d;
        int   stall;
        exp_t e;
        d = v.dut;
        stall = 0;
        @(negedge clk);
        req[d] = 1'b1; we[d] = v.we; be[d] = v.be; addr[d] = v.addr; wdata[d] = v.wdata;
        while (rdy[d] !== 1'b1 && stall < 16) begin
            @(negedge clk);
            stall++;
        end
        if (rdy[d] !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout (dut%0d): got ready_o=%b after %0d cycles, want 1", d, rdy[d], stall);
        end else begin
            chk("stall_cycles", d, 32'(stall), 32'(v.exp_stall));
            if (track) begin
                e.err  = v.exp_err;
                e.data = v.exp_data;
                e.cyc  = cyc + lat_of(d);
                push_exp(d, e);
            end
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Latency-1 instance: back-to-back, byte lanes, errors, read-after-write.
        add(0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b0, IDLE_DATA,     0);
        add(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 0);
        add(0, 1'b1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, IDLE_DATA,     0);
        add(0, 1'b1, 4'h5, 32'h0000_0020, 32'h1122_3344, 1'b0, IDLE_DATA,     0);
        add(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'hAA22_CC44, 0);
        add(0, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, IDLE_DATA,     0);
        add(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'hAA22_CC44, 0);
        add(0, 1'b0, 4'h0, 32'h0000_0013, 32'h0,         1'b1, ERR_DATA,      0);
        add(0, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, IDLE_DATA,     0);
        add(0, 1'b1, 4'hF, 32'h0000_4000, 32'h1212_1212, 1'b1, ERR_DATA,      0);
        add(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D, 0);
        add(0, 1'b1, 4'hF, 32'h0000_3FFC, 32'h5A5A_5A5A, 1'b0, IDLE_DATA,     0);
        add(0, 1'b0, 4'h0, 32'h0000_3FFC, 32'h0,         1'b0, 32'h5A5A_5A5A, 0);
        add(0, 1'b1, 4'hF, 32'h0000_0022, 32'h0000_0000, 1'b1, ERR_DATA,      0);
        add(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'hAA22_CC44, 0);
        add(0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, ERR_DATA,      0);
        // Latency-3 instance: each follow-on request stalls two cycles.
        add(1, 1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, IDLE_DATA,     0);
        add(1, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         1'b0, 32'h0BAD_F00D, 2);
        add(1, 1'b0, 4'h0, 32'h0000_0041, 32'h0,         1'b1, ERR_DATA,      2);
        add(1, 1'b1, 4'h3, 32'h0000_0040, 32'hFFFF_1234, 1'b0, IDLE_DATA,     2);
        add(1, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         1'b0, 32'h0BAD_1234, 2);
        // Latency-4 instance: follow-on request stalls three cycles.
        add(2, 1'b1, 4'hF, 32'h0000_0084, 32'h89AB_CDEF, 1'b0, IDLE_DATA,     0);
        add(2, 1'b0, 4'h0, 32'h0000_0084, 32'h0,         1'b0, 32'h89AB_CDEF, 3);

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
            be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
        end

        // Reset held for three cycles, then released away from the clock edge.
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("ready_in_reset",  i, 32'(rdy[i]), 32'h0);
                chk("rvalid_in_reset", i, 32'(rv[i]),  32'h0);
            end
        end
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ready_after_release", i, 32'(rdy[i]), 32'h1);

        for (int k = 0; k < tbl.size(); k++) begin
            issue(tbl[k], 1'b1);
        end
        repeat (6) @(negedge clk);

        // Reset during an in-flight latency-4 write: response dropped, write still committed.
        v.dut = 2; v.we = 1'b1; v.be = 4'hF; v.addr = 32'h0000_0080; v.wdata = 32'h7766_5544;
        v.exp_err = 1'b0; v.exp_data = IDLE_DATA; v.exp_stall = 0;
        issue(v, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk("ready_mid_reset", 2, 32'(rdy[2]), 32'h0);
        rst_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        chk("ready_after_midreset", 2, 32'(rdy[2]), 32'h1);
        v.we = 1'b0; v.be = 4'h0; v.wdata = 32'h0; v.exp_data = 32'h7766_5544;
        issue(v, 1'b1);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("queue_drained", i, 32'(qsize(i)), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
